prog_ctr_unit: RTL and testbench
================================

# prog_ctr_unit

Parametrised program-counter unit for the CSE141L processor fetch stage, successor to the single-program relative-branch PC. It adds configurable PC and offset widths, absolute and relative branch modes, a table of per-program start vectors selected on Start, and a hardware return-address stack (RAS) for Call/Ret. Its output addresses instruction ROM directly; its inputs come from the control decoder and ALU flag.

## Interface
- PC_W, 10, program counter width; all PC arithmetic is modulo 2^PC_W.
- OFF_W, 6, width of the signed two's-complement relative offset Target.
- NUM_PROGS, 3, number of program start vectors.
- PROG_BASE, 30'h1002_0000, packed start vectors; slot i at bits [i*PC_W +: PC_W] (defaults: 0, 128, 256).
- RAS_DEPTH, 4, return-address stack entries (≥1).

Ports:
- Clk  in  1  clock; all state changes on rising edge only.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  hold/load: while high, PC is loaded with the selected start vector.
- ProgSel  in  $clog2(NUM_PROGS)  start-vector select, sampled while Start is high.
- BranchEn  in  1  conditional-branch instruction.
- ALU_flag  in  1  branch condition from ALU.
- BranchAbs  in  1  target mode for branch and Call: 1 = AbsTarget, 0 = PC + sext(Target).
- Target  in  OFF_W  signed relative offset.
- AbsTarget  in  PC_W  absolute target address.
- Call  in  1  unconditional call: push return address, then jump.
- Ret  in  1  return: pop the RAS into PC.
- ProgCtr  out  PC_W  program counter register.
- RasEmpty  out  1  RAS holds 0 entries.
- RasFull  out  1  RAS holds RAS_DEPTH entries.
- Fault  out  1  sticky RAS overflow/underflow flag.

## Operation
- Next-PC priority, highest first: Reset > Start > Ret > Call > taken branch (BranchEn && ALU_flag) > ProgCtr+1.
- Start: ProgCtr <= PROG_BASE slot ProgSel; ProgSel ≥ NUM_PROGS selects slot 0. Also clears RAS count and Fault. PC stays at the vector while Start is held; execution begins on the first edge after Start falls.
- Target calc: relative = ProgCtr + sign-extend(Target) to PC_W, wrapping; absolute = AbsTarget.
- Call: push ProgCtr+1 (wrapped), ProgCtr <= target. If the RAS is full, the push is dropped (contents and count unchanged), the jump is still taken, and Fault is set.
- Ret: ProgCtr <= top entry, count decrements. If the RAS is empty, ProgCtr <= ProgCtr+1 and Fault is set.
- Ret and Call in the same cycle: Ret executes and Call is ignored. Call overrides a concurrent branch.
- Fault clears only on Reset or Start.
- RAS is a LIFO of RAS_DEPTH × PC_W registers plus a count of width $clog2(RAS_DEPTH+1). RasEmpty = (count==0) and RasFull = (count==RAS_DEPTH), both combinational from the registered count.

## Timing
- Reset (asynchronous, takes effect immediately): ProgCtr = PROG_BASE slot 0, RAS count = 0, Fault = 0, RasEmpty = 1, RasFull = 0. RAS entry contents are don't-care.
- Every control input is sampled on the rising edge. ProgCtr, count and Fault update on that same edge, giving 1-cycle latency.
- Branch, Call and Ret redirect with no bubble. The instruction at the new PC is fetched in the next cycle.
- Reset deassertion mid-program: PC restarts at slot 0 and any RAS contents are lost.

## Configuration
- PCU_RAS_EN defined: Call/Ret and the RAS behave as specified above.
- PCU_RAS_EN undefined: no RAS storage is built. Call acts as an unconditional jump with no push. Ret acts as ProgCtr+1. RasEmpty = 1, RasFull = 0, Fault = 0 constantly.

## Test plan
- Reset then Start=1 with ProgSel=2 for 3 cycles, then Start=0 → ProgCtr = 256 while Start is held, then 257, 258.
- From PC=20: BranchEn=1, ALU_flag=1, BranchAbs=0, Target=6'b111101 → PC=17. Repeat with ALU_flag=0 → PC=21.
- Wrap: PC=1023, increment → 0. PC=2, Target=-4 → PC=1022.
- From PC=10: Call, BranchAbs=1, AbsTarget=300 → PC=300. Next cycle Ret → PC=11, RasEmpty=1.
- Five nested Calls with RAS_DEPTH=4 → RasFull after the 4th, Fault=1 after the 5th, PC = 5th target. Four Rets return correctly, a 5th Ret gives PC+1 with Fault still 1. Start then clears Fault.
- Call and Ret asserted together with 1 entry in the RAS → pop only, count = 0. Also assert Reset mid-cycle → outputs go to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/prog_ctr_unit_if.sv
// Signal bundle between the control decoder / ALU flag and the program-counter unit.
// The master side drives control and observes the PC; the unit itself is the slave.
interface prog_ctr_unit_if #(
   parameter int PC_W  = 10,
   parameter int OFF_W = 6,
   parameter int SEL_W = 2
);
   logic                    Start;
   logic [SEL_W-1:0]        ProgSel;
   logic                    BranchEn;
   logic                    ALU_flag;
   logic                    BranchAbs;
   logic signed [OFF_W-1:0] Target;
   logic [PC_W-1:0]         AbsTarget;
   logic                    Call;
   logic                    Ret;
   logic [PC_W-1:0]         ProgCtr;
   logic                    RasEmpty;
   logic                    RasFull;
   logic                    Fault;

   modport master (
      output Start, ProgSel, BranchEn, ALU_flag, BranchAbs, Target, AbsTarget, Call, Ret,
      input  ProgCtr, RasEmpty, RasFull, Fault
   );

   modport slave (
      input  Start, ProgSel, BranchEn, ALU_flag, BranchAbs, Target, AbsTarget, Call, Ret,
      output ProgCtr, RasEmpty, RasFull, Fault
   );
endinterface

// File: rtl/prog_ctr_unit.sv
// Fetch-stage program counter with start vectors, absolute/relative branches and an
// optional return-address stack for Call/Ret, built only when PCU_RAS_EN is defined.
module prog_ctr_unit #(
   parameter int                          PC_W      = 10,
   parameter int                          OFF_W     = 6,
   parameter int                          NUM_PROGS = 3,
   parameter logic [NUM_PROGS*PC_W-1:0]   PROG_BASE = 30'h1002_0000,
   parameter int                          RAS_DEPTH = 4
) (
   input  logic           Clk,
   input  logic           Reset,
   prog_ctr_unit_if.slave pcu
);
   localparam int SEL_W = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;

   if (PC_W < OFF_W) begin : g_bad_off_w
      $error("prog_ctr_unit: OFF_W must not exceed PC_W");
   end
   if (RAS_DEPTH < 1) begin : g_bad_ras_depth
      $error("prog_ctr_unit: RAS_DEPTH must be at least 1");
   end
   if (NUM_PROGS < 1) begin : g_bad_num_progs
      $error("prog_ctr_unit: NUM_PROGS must be at least 1");
   end

   // Out-of-range selects fall back to slot 0, which is also the reset vector.
   function automatic logic [PC_W-1:0] start_vec(input logic [SEL_W-1:0] sel);
      logic [PC_W-1:0] v;
      v = PROG_BASE[PC_W-1:0];
      for (int i = 1; i < NUM_PROGS; i++) begin
         if (sel == SEL_W'(i)) v = PROG_BASE[i*PC_W +: PC_W];
      end
      return v;
   endfunction

   function automatic logic [PC_W-1:0] sext_off(input logic signed [OFF_W-1:0] off);
      logic signed [PC_W-1:0] ext;
      ext = PC_W'(off);
      return ext;
   endfunction

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] jump_tgt;
   logic            branch_taken;

   assign pc_inc       = pc_q + PC_W'(1);
   assign jump_tgt     = pcu.BranchAbs ? pcu.AbsTarget : pc_q + sext_off(pcu.Target);
   assign branch_taken = pcu.BranchEn && pcu.ALU_flag;

`ifdef PCU_RAS_EN
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);
   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

   logic [PC_W-1:0]  ras_q [RAS_DEPTH];
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             fault_q;
   logic             fault_d;
   logic             push_en;
   logic             ras_empty;
   logic             ras_full;
   logic [PTR_W-1:0] push_idx;
   logic [PTR_W-1:0] top_idx;

   assign ras_empty = (cnt_q == '0);
   assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
   assign push_idx  = PTR_W'(cnt_q);
   assign top_idx   = PTR_W'(cnt_q - CNT_W'(1));

   always_comb begin
      pc_d    = pc_inc;
      cnt_d   = cnt_q;
      fault_d = fault_q;
      push_en = 1'b0;
      if (pcu.Start) begin
         pc_d    = start_vec(pcu.ProgSel);
         cnt_d   = '0;
         fault_d = 1'b0;
      end else if (pcu.Ret) begin
         // Underflow still advances sequentially so fetch never stalls.
         if (ras_empty) begin
            fault_d = 1'b1;
         end else begin
            pc_d  = ras_q[top_idx];
            cnt_d = cnt_q - CNT_W'(1);
         end
      end else if (pcu.Call) begin
         pc_d = jump_tgt;
         if (ras_full) begin
            fault_d = 1'b1;
         end else begin
            push_en = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
         end
      end else if (branch_taken) begin
         pc_d = jump_tgt;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pc_q    <= PROG_BASE[PC_W-1:0];
         cnt_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end

   // Stack storage carries no reset; entries above the count are never read.
   always_ff @(posedge Clk) begin
      if (push_en) ras_q[push_idx] <= pc_inc;
   end

   assign pcu.RasEmpty = ras_empty;
   assign pcu.RasFull  = ras_full;
   assign pcu.Fault    = fault_q;
`else
   always_comb begin
      pc_d = pc_inc;
      if (pcu.Start) begin
         pc_d = start_vec(pcu.ProgSel);
      end else if (pcu.Ret) begin
         pc_d = pc_inc;
      end else if (pcu.Call || branch_taken) begin
         pc_d = jump_tgt;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) pc_q <= PROG_BASE[PC_W-1:0];
      else       pc_q <= pc_d;
   end

   assign pcu.RasEmpty = 1'b1;
   assign pcu.RasFull  = 1'b0;
   assign pcu.Fault    = 1'b0;
`endif

   assign pcu.ProgCtr = pc_q;
endmodule

// File: tb/tb_prog_ctr_unit.sv
// Bench for prog_ctr_unit: directed vector table, hand sequences for the stack corners
// and asynchronous reset, then randomized traffic against a queue-based reference model.
module tb_prog_ctr_unit;
   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   prog_ctr_unit_if #(.PC_W(10), .OFF_W(6), .SEL_W(2)) bus ();

   prog_ctr_unit dut (
      .Clk   (Clk),
      .Reset (Reset),
      .pcu   (bus)
   );

`ifdef PCU_RAS_EN
   localparam bit RAS_ON    = 1'b1;
   localparam int RAS_DEPTH = 4;
`else
   localparam bit RAS_ON    = 1'b0;
`endif

   int checks   = 0;
   int failures = 0;

   int m_pc;
   bit m_fault;
   int m_stk[$];

   typedef struct {
      bit st; int sel; bit br; bit fl; bit ab; int off; int at; bit cl; bit rt; int exp_pc;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int wrap(input int v);
      return ((v % 1024) + 1024) % 1024;
   endfunction

   function automatic int base_of(input int sel);
      case (sel)
         1:       return 128;
         2:       return 256;
         default: return 0;
      endcase
   endfunction

   task automatic drive(input bit st, input int sel, input bit br, input bit fl, input bit ab,
                        input int off, input int at, input bit cl, input bit rt);
      bus.Start     = st;
      bus.ProgSel   = 2'(sel);
      bus.BranchEn  = br;
      bus.ALU_flag  = fl;
      bus.BranchAbs = ab;
      bus.Target    = 6'(off);
      bus.AbsTarget = 10'(at);
      bus.Call      = cl;
      bus.Ret       = rt;
   endtask

   // Next state from the architectural rules, using the inputs currently applied.
   task automatic model_step();
      int off;
      int tgt;
      off = bus.Target[5] ? int'(bus.Target[4:0]) - 32 : int'(bus.Target[4:0]);
      tgt = bus.BranchAbs ? int'(bus.AbsTarget) : wrap(m_pc + off);
      if (bus.Start) begin
         m_pc    = base_of(int'(bus.ProgSel));
         m_fault = 1'b0;
         m_stk.delete();
      end else if (bus.Ret) begin
`ifdef PCU_RAS_EN
         if (m_stk.size() == 0) begin
            m_pc    = wrap(m_pc + 1);
            m_fault = 1'b1;
         end else begin
            m_pc = m_stk.pop_back();
         end
`else
         m_pc = wrap(m_pc + 1);
`endif
      end else if (bus.Call) begin
`ifdef PCU_RAS_EN
         if (m_stk.size() == RAS_DEPTH) m_fault = 1'b1;
         else                           m_stk.push_back(wrap(m_pc + 1));
`endif
         m_pc = tgt;
      end else if (bus.BranchEn && bus.ALU_flag) begin
         m_pc = tgt;
      end else begin
         m_pc = wrap(m_pc + 1);
      end
   endtask

   task automatic check_model(input string tag);
      bit e_empty;
      bit e_full;
`ifdef PCU_RAS_EN
      e_empty = (m_stk.size() == 0);
      e_full  = (m_stk.size() == RAS_DEPTH);
`else
      e_empty = 1'b1;
      e_full  = 1'b0;
`endif
      chk({tag, "_pc"},    bus.ProgCtr,  m_pc);
      chk({tag, "_empty"}, bus.RasEmpty, e_empty);
      chk({tag, "_full"},  bus.RasFull,  e_full);
      chk({tag, "_fault"}, bus.Fault,    m_fault);
   endtask

   task automatic step(input string tag);
      model_step();
      @(posedge Clk);
      #1;
      check_model(tag);
   endtask

   task automatic model_reset();
      m_pc    = 0;
      m_fault = 1'b0;
      m_stk.delete();
   endtask

   initial begin
      int exp_ret[5];
      int exp_callret;

`ifdef PCU_RAS_EN
      exp_ret     = '{301, 201, 101, 1, 2};
      exp_callret = 1;
`else
      exp_ret     = '{501, 502, 503, 504, 505};
      exp_callret = 51;
`endif

      // st sel br fl ab off at cl rt exp_pc
      tbl.push_back('{1, 2, 0, 0, 0,   0,    0, 0, 0,  256});
      tbl.push_back('{1, 2, 0, 0, 0,   0,    0, 0, 0,  256});
      tbl.push_back('{1, 2, 0, 0, 0,   0,    0, 0, 0,  256});
      tbl.push_back('{0, 0, 0, 0, 0,   0,    0, 0, 0,  257});
      tbl.push_back('{0, 0, 0, 0, 0,   0,    0, 0, 0,  258});
      tbl.push_back('{1, 3, 0, 0, 0,   0,    0, 0, 0,    0});
      tbl.push_back('{1, 1, 1, 1, 1,   0,  999, 1, 1,  128});
      tbl.push_back('{0, 0, 1, 1, 1,   0,   20, 0, 0,   20});
      tbl.push_back('{0, 0, 1, 1, 0,  -3,    0, 0, 0,   17});
      tbl.push_back('{0, 0, 1, 1, 1,   0,   20, 0, 0,   20});
      tbl.push_back('{0, 0, 1, 0, 0,  -3,    0, 0, 0,   21});
      tbl.push_back('{0, 0, 1, 1, 1,   0, 1023, 0, 0, 1023});
      tbl.push_back('{0, 0, 0, 0, 0,   0,    0, 0, 0,    0});
      tbl.push_back('{0, 0, 1, 1, 1,   0,    2, 0, 0,    2});
      tbl.push_back('{0, 0, 1, 1, 0,  -4,    0, 0, 0, 1022});
      tbl.push_back('{0, 0, 0, 1, 0,   5,    0, 0, 0, 1023});
      tbl.push_back('{0, 0, 1, 1, 0,  31,    0, 0, 0,   30});
      tbl.push_back('{0, 0, 1, 1, 0, -32,    0, 0, 0, 1022});
      tbl.push_back('{0, 0, 1, 1, 1,   0,   10, 0, 0,   10});
      tbl.push_back('{0, 0, 0, 0, 1,   0,  300, 1, 0,  300});
      tbl.push_back('{0, 0, 0, 0, 0,   0,    0, 0, 1, RAS_ON ? 11 : 301});

      Reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(posedge Clk);
      #1;
      check_model("reset");
      Reset = 1'b0;

      foreach (tbl[i]) begin
         drive(tbl[i].st, tbl[i].sel, tbl[i].br, tbl[i].fl, tbl[i].ab,
               tbl[i].off, tbl[i].at, tbl[i].cl, tbl[i].rt);
         step($sformatf("vec%0d", i));
         chk($sformatf("vec%0d_tbl_pc", i), bus.ProgCtr, tbl[i].exp_pc);
      end

      // Nested calls past the stack depth, then unwind past empty.
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step("nest_start");
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 0, 1, 0, (i + 1) * 100, 1, 0);
         step("nest_call");
         chk("nest_call_pc", bus.ProgCtr, (i + 1) * 100);
         if (i == 3) chk("nest_full_after4", bus.RasFull, RAS_ON);
      end
      chk("nest_fault_after5", bus.Fault, RAS_ON);
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
         step("nest_ret");
         chk("nest_ret_pc", bus.ProgCtr, exp_ret[i]);
      end
      chk("nest_fault_sticky", bus.Fault, RAS_ON);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step("nest_clear");
      chk("start_clears_fault", bus.Fault, 1'b0);

      // Call and Ret together with one entry stacked: only the pop happens.
      drive(0, 0, 0, 0, 1, 0, 50, 1, 0);
      step("cr_call");
      drive(0, 0, 1, 1, 1, 0, 700, 1, 1);
      step("cr_both");
      chk("callret_pc", bus.ProgCtr, exp_callret);
      chk("callret_empty", bus.RasEmpty, 1'b1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      step("cr_underflow");

      // Asynchronous reset between clock edges.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      Reset = 1'b1;
      #1;
      model_reset();
      check_model("async_reset");
      #2;
      Reset = 1'b0;
      step("post_reset");

      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(99) < 4, $urandom_range(3), $urandom_range(1), $urandom_range(1),
               $urandom_range(1), int'($urandom_range(63)) - 32, $urandom_range(1023),
               $urandom_range(99) < 20, $urandom_range(99) < 18);
         step("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
